quiz_round_ctrl: RTL

Round sequencer for the speed mental-conversion quiz. Per round it loads a 4-bit question from the random source, runs a per-second countdown, accepts one answer, judges it and updates the score. It also selects the 4-bit value (time left or score) that feeds the tens/ones digit splitter for the 7-segment display.

---
 rtl/quiz_pkg.sv | 28 ++
 rtl/sec_tick_gen.sv | 36 +++
 rtl/quiz_round_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/quiz_pkg.sv
`default_nettype none
// ============================================================================
// quiz_pkg : states and shared constants for the quiz round sequencer
// Revision : 1.0
// ============================================================================
package quiz_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] SCORE_MAX = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ASK   = 3'd2,
    ST_JUDGE = 3'd3,
    ST_SHOW  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic logic [DIGIT_W-1:0] sat_add(input logic [DIGIT_W-1:0] a,
                                                 input logic [1:0]         inc);
    logic [DIGIT_W:0] sum;
    sum = {1'b0, a} + (DIGIT_W+1)'(inc);
    return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[DIGIT_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sec_tick_gen.sv
`default_nettype none
// ============================================================================
// sec_tick_gen : divides clk by TICK_DIV, one-cycle tick on each wrap
// Revision     : 1.0
// ============================================================================
module sec_tick_gen
  import quiz_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = en && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/quiz_round_ctrl.sv
`default_nettype none
// ============================================================================
// quiz_round_ctrl : per-round question/countdown/judge/score sequencer
//                   optional QUIZ_STREAK_EN: every third straight hit scores 2
// Revision        : 1.0
// ============================================================================
module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int TICK_DIV    = 50000000,
  parameter int TIME_LIMIT  = 9,
  parameter int NUM_ROUNDS  = 5,
  parameter int SHOW_CYCLES = 100000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DIGIT_W-1:0] rand_val,
  input  logic               ans_valid,
  input  logic [DIGIT_W-1:0] ans_data,
  output logic [DIGIT_W-1:0] question,
  output logic [DIGIT_W-1:0] disp_val,
  output logic               disp_is_score,
  output logic [DIGIT_W-1:0] time_left,
  output logic [DIGIT_W-1:0] score,
  output logic               busy,
  output logic               correct,
  output logic               wrong,
  output logic               game_over
);

  localparam int SHOW_W = $clog2(SHOW_CYCLES + 1);
  localparam logic [SHOW_W-1:0]  SHOW_LAST  = SHOW_W'(SHOW_CYCLES - 1);
  localparam logic [DIGIT_W-1:0] TIME_INIT  = DIGIT_W'(TIME_LIMIT);
  localparam logic [DIGIT_W-1:0] ROUND_LAST = DIGIT_W'(NUM_ROUNDS - 1);

  state_t             r_state, w_nxt_state;
  logic [DIGIT_W-1:0] w_nxt_time, w_nxt_score;
  logic [DIGIT_W-1:0] r_round;
  logic [SHOW_W-1:0]  r_show;
  logic [1:0]         w_inc;
  logic               w_tick, w_show_end, w_accept, w_timeout_now;
  logic               w_game_start, w_time_view;

  sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (r_state == ST_LOAD),
    .en    (r_state == ST_ASK),
    .tick  (w_tick)
  );

  assign w_show_end    = (r_show == SHOW_LAST);
  assign w_accept      = (r_state == ST_ASK) && ans_valid;
  // an answer arriving on the final tick takes priority over the timeout
  assign w_timeout_now = (r_state == ST_ASK) && !ans_valid && w_tick && (time_left == 4'd1);
  assign w_game_start  = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
  assign w_time_view   = (w_nxt_state == ST_LOAD) || (w_nxt_state == ST_ASK);

`ifdef QUIZ_STREAK_EN
  logic [1:0] r_streak;

  assign w_inc = (r_streak == 2'd2) ? 2'd2 : 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= 2'd0;
    end else if (w_game_start) begin
      r_streak <= 2'd0;
    end else if (r_state == ST_JUDGE) begin
      r_streak <= (correct && (r_streak != 2'd2)) ? r_streak + 2'd1 : 2'd0;
    end
  end
`else
  assign w_inc = 2'd1;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_time  = time_left;
    w_nxt_score = score;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_nxt_state = ST_LOAD;
          w_nxt_score = '0;
        end
      end
      ST_LOAD: begin
        w_nxt_time  = TIME_INIT;
        w_nxt_state = ST_ASK;
      end
      ST_ASK: begin
        if (ans_valid) begin
          w_nxt_state = ST_JUDGE;
        end else if (w_tick) begin
          w_nxt_time = time_left - 4'd1;
          if (time_left == 4'd1) w_nxt_state = ST_JUDGE;
        end
      end
      ST_JUDGE: begin
        w_nxt_state = ST_SHOW;
        if (correct) w_nxt_score = sat_add(score, w_inc);
      end
      ST_SHOW: begin
        if (w_show_end) w_nxt_state = (r_round == ROUND_LAST) ? ST_DONE : ST_LOAD;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      question      <= '0;
      time_left     <= '0;
      score         <= '0;
      disp_val      <= '0;
      disp_is_score <= 1'b0;
      busy          <= 1'b0;
      correct       <= 1'b0;
      wrong         <= 1'b0;
      game_over     <= 1'b0;
      r_round       <= '0;
      r_show        <= '0;
    end else begin
      r_state       <= w_nxt_state;
      time_left     <= w_nxt_time;
      score         <= w_nxt_score;
      // display source follows the next state so it moves with its source
      disp_val      <= w_time_view ? w_nxt_time : w_nxt_score;
      disp_is_score <= !w_time_view;
      busy          <= (w_nxt_state inside {ST_LOAD, ST_ASK, ST_JUDGE, ST_SHOW});
      game_over     <= (w_nxt_state == ST_DONE);
      correct       <= w_accept && (ans_data == question);
      wrong         <= (w_accept && (ans_data != question)) || w_timeout_now;
      if (r_state == ST_LOAD) question <= rand_val;
      r_show        <= (r_state == ST_SHOW) ? r_show + SHOW_W'(1) : '0;
      if (w_game_start) begin
        r_round <= '0;
      end else if ((r_state == ST_SHOW) && w_show_end) begin
        r_round <= r_round + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire
